// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read arbiter: FSM states, slave
// indices, route codes and the slave address map.
package axi_arb_pkg;

    // Encodings match the Read_State_control output directly.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAddr = 2'b01,
        StData = 2'b10
    } arb_state_e;

    localparam logic [2:0] S0    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S2    = 3'd2;
    localparam logic [2:0] S3    = 3'd3;
    localparam logic [2:0] S4    = 3'd4;
    localparam logic [2:0] SDEF  = 3'd5;
    localparam logic [2:0] SNONE = 3'd7;

    // Route code driven when nothing is granted: master bit 0, slave SNONE.
    localparam logic [3:0] ROUTE_NONE = {1'b0, SNONE};

    localparam logic [31:0] S0_BASE  = 32'h0000_0000;
    localparam logic [31:0] S0_LIMIT = 32'h0000_1FFF;
    localparam logic [31:0] S1_BASE  = 32'h0001_0000;
    localparam logic [31:0] S1_LIMIT = 32'h0001_FFFF;
    localparam logic [31:0] S2_BASE  = 32'h0002_0000;
    localparam logic [31:0] S2_LIMIT = 32'h0002_FFFF;
    localparam logic [31:0] S3_BASE  = 32'h1000_0000;
    localparam logic [31:0] S3_LIMIT = 32'h1000_03FF;
    localparam logic [31:0] S4_BASE  = 32'h2000_0000;
    localparam logic [31:0] S4_LIMIT = 32'h201F_FFFF;

    // Inclusive range check used by the address decoder.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

    // Pick one per-slave bit (S0..S4, default) by slave index; SNONE and
    // other unused codes read as 0.
    function automatic logic slave_bit(input logic [5:0] vec, input logic [2:0] idx);
        logic [7:0] ext;
        ext = {2'b00, vec};
        return ext[idx];
    endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational read-address decoder: 32-bit address to 3-bit slave index.
// Addresses outside every slave window go to the default slave.
module axi_addr_decoder
    import axi_arb_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  slave_sel
);

    // Windows do not overlap, so the check order does not matter.
    always_comb begin
        slave_sel = SDEF;
        if (in_range(addr, S0_BASE, S0_LIMIT)) begin
            slave_sel = S0;
        end else if (in_range(addr, S1_BASE, S1_LIMIT)) begin
            slave_sel = S1;
        end else if (in_range(addr, S2_BASE, S2_LIMIT)) begin
            slave_sel = S2;
        end else if (in_range(addr, S3_BASE, S3_LIMIT)) begin
            slave_sel = S3;
        end else if (in_range(addr, S4_BASE, S4_LIMIT)) begin
            slave_sel = S4;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-side arbiter for the two-master, five-slave AXI interconnect.
// Fixed priority M0 over M1, one outstanding read at a time; the route code
// is held in grant_q from the address handshake until the RLAST beat.
// Optional DATA-state watchdog compiled in with `define ARB_TIMEOUT_EN.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        ARVALID_M0,
    input  logic        ARVALID_M1,
    input  logic [31:0] ARADDR_M0,
    input  logic [31:0] ARADDR_M1,
    input  logic [5:0]  ARREADY_S,
    input  logic [5:0]  RVALID_S,
    input  logic [5:0]  RLAST_S,
    input  logic        RREADY_M0,
    input  logic        RREADY_M1,
    output logic [1:0]  Read_State_control,
    output logic [3:0]  ARID_control,
    output logic        timeout_err
);

    arb_state_e state_q, state_d;
    logic [3:0] grant_q, grant_d;

    logic [2:0] dec_m0, dec_m1;
    logic       req_any;
    logic       win_m1;
    logic [3:0] idle_route;
    logic       ar_ready_idle;
    logic       ar_ready_grant;
    logic       beat;
    logic       last_beat;
    logic       timeout_fire;

    axi_addr_decoder u_dec_m0 (
        .addr      (ARADDR_M0),
        .slave_sel (dec_m0)
    );

    axi_addr_decoder u_dec_m1 (
        .addr      (ARADDR_M1),
        .slave_sel (dec_m1)
    );

    // Winner selection and per-slave handshake/beat qualification.
    always_comb begin
        req_any        = !ARESET && (ARVALID_M0 || ARVALID_M1);
        win_m1         = !ARVALID_M0;
        idle_route     = {win_m1, win_m1 ? dec_m1 : dec_m0};
        ar_ready_idle  = slave_bit(ARREADY_S, idle_route[2:0]);
        ar_ready_grant = slave_bit(ARREADY_S, grant_q[2:0]);
        // Beat uses only registered routing, so no R-channel signal reaches
        // ARID_control combinationally.
        beat           = slave_bit(RVALID_S, grant_q[2:0])
                         & (grant_q[3] ? RREADY_M1 : RREADY_M0);
        last_beat      = beat & slave_bit(RLAST_S, grant_q[2:0]);
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Watchdog: counts beat-less DATA cycles, fires on the cycle that
    // brings the count to TIMEOUT_CYCLES.
    always_comb begin
        cnt_d        = cnt_q;
        timeout_fire = 1'b0;
        if (state_q != StData || beat) begin
            cnt_d = '0;
        end else if (cnt_q == TimeoutLast) begin
            cnt_d        = '0;
            timeout_fire = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_fire          = 1'b0;
`endif

    // Next-state, grant capture and route output.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ARID_control = grant_q;
        unique case (state_q)
            StIdle: begin
                ARID_control = ROUTE_NONE;
                grant_d      = ROUTE_NONE;
                if (req_any) begin
                    ARID_control = idle_route;
                    grant_d      = idle_route;
                    state_d      = ar_ready_idle ? StData : StAddr;
                end
            end
            StAddr: begin
                if (ar_ready_grant) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (last_beat || timeout_fire) begin
                    state_d = StIdle;
                    grant_d = ROUTE_NONE;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = ROUTE_NONE;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= StIdle;
            grant_q <= ROUTE_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign Read_State_control = state_q;
    assign timeout_err        = timeout_fire;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ARVALID_M0, ARVALID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [5:0]  ARREADY_S, RVALID_S, RLAST_S;
    logic        RREADY_M0, RREADY_M1;
    logic [1:0]  Read_State_control;
    logic [3:0]  ARID_control;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] dec_addr [12] = '{32'h0000_1FFF, 32'h0000_2000, 32'h0001_0000,
                                   32'h0001_FFFF, 32'h0002_FFFF, 32'h0003_0000,
                                   32'h1000_03FF, 32'h1000_0400, 32'h0FFF_FFFF,
                                   32'h201F_FFFF, 32'h2020_0000, 32'h1FFF_FFFF};
    logic [2:0]  dec_slv  [12] = '{3'd0, 3'd5, 3'd1, 3'd1, 3'd2, 3'd5,
                                   3'd3, 3'd5, 3'd5, 3'd4, 3'd5, 3'd5};

    axi_read_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .ARVALID_M0         (ARVALID_M0),
        .ARVALID_M1         (ARVALID_M1),
        .ARADDR_M0          (ARADDR_M0),
        .ARADDR_M1          (ARADDR_M1),
        .ARREADY_S          (ARREADY_S),
        .RVALID_S           (RVALID_S),
        .RLAST_S            (RLAST_S),
        .RREADY_M0          (RREADY_M0),
        .RREADY_M1          (RREADY_M1),
        .Read_State_control (Read_State_control),
        .ARID_control       (ARID_control),
        .timeout_err        (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [5:0] obs();
        return {Read_State_control, ARID_control};
    endfunction

    task automatic clear_inputs();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        ARADDR_M0  = '0;   ARADDR_M1  = '0;
        ARREADY_S  = '0;   RVALID_S   = '0;   RLAST_S = '0;
        RREADY_M0  = 1'b0; RREADY_M1  = 1'b0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        clear_inputs();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", obs(), 6'b00_0111);
        end
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err);
        end
        tick();
        ARESET = 1'b0;
    endtask

    task automatic test_basic();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0004; ARREADY_S = 6'b000010;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0001) begin
            bad++; $display("FAIL basic_idle_grant: got %b want %b", obs(), 6'b00_0001);
        end
        tick();
        ARVALID_M0 = 1'b0; ARREADY_S = '0;
        RVALID_S = 6'b000010; RLAST_S = 6'b000010; RREADY_M0 = 1'b1;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_0001) begin
            bad++; $display("FAIL basic_data: got %b want %b", obs(), 6'b10_0001);
        end
        tick();
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL basic_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_priority();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0100;
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0000;
        ARREADY_S  = 6'b000101;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0000) begin
            bad++; $display("FAIL prio_m0_first: got %b want %b", obs(), 6'b00_0000);
        end
        tick();
        ARVALID_M0 = 1'b0; ARREADY_S = '0;
        RVALID_S = 6'b000001; RLAST_S = 6'b000001; RREADY_M0 = 1'b1;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_0000) begin
            bad++; $display("FAIL prio_m0_data: got %b want %b", obs(), 6'b10_0000);
        end
        tick();
        RVALID_S = '0; RLAST_S = '0; RREADY_M0 = 1'b0; ARREADY_S = 6'b000100;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_1010) begin
            bad++; $display("FAIL prio_m1_granted: got %b want %b", obs(), 6'b00_1010);
        end
        tick();
        ARVALID_M1 = 1'b0; ARREADY_S = '0;
        RVALID_S = 6'b000100; RLAST_S = 6'b000100; RREADY_M1 = 1'b1;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_1010) begin
            bad++; $display("FAIL prio_m1_data: got %b want %b", obs(), 6'b10_1010);
        end
        tick();
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL prio_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_addr_wait();
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h2000_0040; ARREADY_S = '0;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_1100) begin
            bad++; $display("FAIL wait_idle: got %b want %b", obs(), 6'b00_1100);
        end
        tick();
        ARVALID_M1 = 1'b0;
        // M0 requests and S0 is ready during ADDR; both must be ignored.
        for (int i = 0; i < 3; i++) begin
            ARVALID_M0 = (i < 2);
            ARADDR_M0  = 32'h0000_0010;
            ARREADY_S  = (i == 2) ? 6'b010000 : 6'b000001;
            @(negedge ACLK);
            total++;
            if (obs() !== 6'b01_1100) begin
                bad++; $display("FAIL wait_addr[%0d]: got %b want %b", i, obs(), 6'b01_1100);
            end
            tick();
        end
        ARVALID_M0 = 1'b0; ARREADY_S = '0;
        RVALID_S = 6'b010000; RLAST_S = 6'b010000; RREADY_M1 = 1'b1;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_1100) begin
            bad++; $display("FAIL wait_data: got %b want %b", obs(), 6'b10_1100);
        end
        tick();
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL wait_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_default_slave();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h3000_0000; ARREADY_S = 6'b100000;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0101) begin
            bad++; $display("FAIL dflt_grant: got %b want %b", obs(), 6'b00_0101);
        end
        tick();
        ARVALID_M0 = 1'b0; ARREADY_S = '0;
        RVALID_S = 6'b100000; RLAST_S = 6'b100000; RREADY_M0 = 1'b1;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_0101) begin
            bad++; $display("FAIL dflt_data: got %b want %b", obs(), 6'b10_0101);
        end
        tick();
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL dflt_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [6:0] v, r, l;
        // Beats land on cycles 0, 4, 5, 6; cycle 3 shows RLAST without RVALID.
        v = 7'b1110111;
        r = 7'b1111001;
        l = 7'b1001000;
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0010; ARREADY_S = 6'b000100;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_1010) begin
            bad++; $display("FAIL burst_grant: got %b want %b", obs(), 6'b00_1010);
        end
        tick();
        ARVALID_M1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            RVALID_S  = {3'b000, v[i], 2'b00};
            RLAST_S   = {3'b000, l[i], 2'b00};
            RREADY_M1 = r[i];
            RREADY_M0 = !r[i];
            ARREADY_S = i[0] ? 6'b111111 : 6'b000000;
            @(negedge ACLK);
            total++;
            if (obs() !== 6'b10_1010) begin
                bad++; $display("FAIL burst_data[%0d]: got %b want %b", i, obs(), 6'b10_1010);
            end
            tick();
        end
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL burst_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_timeout();
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000; ARREADY_S = 6'b000010;
        tick();
        ARVALID_M0 = 1'b0; ARREADY_S = '0; RREADY_M0 = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge ACLK);
            total++;
            if (obs() !== 6'b10_0001 || timeout_err !== (k == 8)) begin
                bad++;
                $display("FAIL timeout_cycle[%0d]: got %b/%b want %b/%b",
                         k, obs(), timeout_err, 6'b10_0001, (k == 8));
            end
            tick();
        end
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_abort: got %b/%b want %b/0", obs(), timeout_err, 6'b00_0111);
        end
        tick();
`else
        for (int k = 1; k <= 10; k++) begin
            @(negedge ACLK);
            total++;
            if (obs() !== 6'b10_0001 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL no_watchdog[%0d]: got %b/%b want %b/0",
                         k, obs(), timeout_err, 6'b10_0001);
            end
            tick();
        end
        RVALID_S = 6'b000010; RLAST_S = 6'b000010;
        tick();
        clear_inputs();
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL no_watchdog_done: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_data();
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0000; ARREADY_S = 6'b000100;
        tick();
        ARVALID_M1 = 1'b0; ARREADY_S = '0;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b10_1010) begin
            bad++; $display("FAIL rst_pre_data: got %b want %b", obs(), 6'b10_1010);
        end
        #1 ARESET = 1'b1;
        #1;
        total++;
        if (obs() !== 6'b00_0111 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got %b/%b want %b/0", obs(), timeout_err, 6'b00_0111);
        end
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        total++;
        if (obs() !== 6'b00_0111) begin
            bad++; $display("FAIL rst_release: got %b want %b", obs(), 6'b00_0111);
        end
        tick();
    endtask

    task automatic test_decode_bounds();
        for (int i = 0; i < 12; i++) begin
            ARVALID_M0 = !i[0]; ARADDR_M0 = dec_addr[i];
            ARVALID_M1 = i[0];  ARADDR_M1 = dec_addr[i];
            ARREADY_S  = '0;
            @(negedge ACLK);
            total++;
            if (obs() !== {2'b00, i[0], dec_slv[i]}) begin
                bad++;
                $display("FAIL decode[%h]: got %b want %b",
                         dec_addr[i], obs(), {2'b00, i[0], dec_slv[i]});
            end
            #1;
            clear_inputs();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish want finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_addr_wait();
        test_default_slave();
        test_burst();
        test_decode_bounds();
        test_timeout();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-side arbiter and address decoder for the two-master, five-slave AXI interconnect. It picks one of M0 (IF) and M1 (MEM) per read transaction and decodes the target slave from ARADDR. It drives the state code and route code that the read address and read data channel muxes consume, and holds the grant until the last read beat completes. Only one read transaction is outstanding across the whole interconnect at a time.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: DATA-state watchdog limit; only used when the watchdog is compiled in.

Ports:
- ACLK  in  1  bus clock
- ARESET  in  1  asynchronous reset, active-high
- ARVALID_M0 / ARVALID_M1  in  1  master read-address valid
- ARADDR_M0 / ARADDR_M1  in  32  master read address, used for decode
- ARREADY_S  in  6  per-slave ARREADY; [0..4] = S0..S4, [5] = default slave
- RVALID_S  in  6  per-slave RVALID, same indexing
- RLAST_S  in  6  per-slave RLAST, same indexing
- RREADY_M0 / RREADY_M1  in  1  master read-data ready
- Read_State_control  out  2  00 IDLE, 01 ADDR, 10 DATA
- ARID_control  out  4  route code: [3] = master, [2:0] = slave (000–100 = S0–S4, 101 = default, 111 = none)
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- Address decode (slave_sel):
  - 0x0000_0000–0x0000_1FFF → S0 ROM
  - 0x0001_0000–0x0001_FFFF → S1 IM
  - 0x0002_0000–0x0002_FFFF → S2 DM
  - 0x1000_0000–0x1000_03FF → S3 sensor
  - 0x2000_0000–0x201F_FFFF → S4 DRAM
  - anything else → 101 (default slave)
- Arbitration: fixed priority, M0 over M1. This matches the address-channel capture order, which also takes M0 first.
- IDLE:
  - No ARVALID: ARID_control = 4'b0111.
  - Otherwise: ARID_control = {winner, decode(winner ARADDR)}, combinationally, and the code is latched into grant_q.
  - Winner ARVALID and the selected ARREADY_S both high in the same cycle → DATA.
  - Winner ARVALID high, selected ARREADY_S low → ADDR.
- ADDR: ARID_control = grant_q. On ARREADY_S[grant_q slave] → DATA. Changes on either master's inputs are ignored.
- DATA: ARID_control = grant_q. The beat is RVALID_S[sel] & RREADY_M[master]. A beat with RLAST_S[sel] set → IDLE.
- Simultaneous ARVALID_M0 and ARVALID_M1 in IDLE: M0 wins; M1 waits in IDLE and is granted on the first IDLE cycle after M0 completes.
- ARESET asserted mid-transaction: immediate return to IDLE, grant_q = 4'b0111, counter cleared. Outstanding beats are dropped.

## Timing
- Reset values: Read_State_control = 00, ARID_control = 4'b0111, timeout_err = 0.
- Read_State_control is registered.
- ARID_control is combinational in IDLE and registered (grant_q) in ADDR and DATA.
- Grant latency is 0 cycles: the route is valid in the same cycle ARVALID is seen in IDLE.
- Minimum transaction: 1 IDLE cycle (address handshake), then DATA until RLAST. After the last beat there is one IDLE cycle before the next grant.
- There is no combinational path from RVALID or RLAST to ARID_control.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to DATA and increments on each DATA cycle with no beat.
  - When the counter reaches TIMEOUT_CYCLES: force IDLE and pulse timeout_err for 1 cycle.
  - The counter also resets on every beat.
- ARB_TIMEOUT_EN undefined: no counter, no abort; timeout_err is tied to 0.

## Structure
- Shared package axi_arb_pkg:
  - state enum (IDLE, ADDR, DATA)
  - slave index constants S0–S4, SDEF = 3'd5, SNONE = 3'd7
  - address range base/limit localparams
- Sub-module axi_addr_decoder: combinational, 32-bit address → 3-bit slave index. Instantiated once per master.

## Test plan
- Reset; M0 ARADDR = 0x0001_0004 with ARVALID; ARREADY_S[1] = 1 → ARID_control = 0001, next state 10. After RLAST beat on S1 → state 00, ARID_control = 0111.
- M0 ARADDR = 0x0000_0100 and M1 ARADDR = 0x0002_0000 valid together → M0→S0 (0000) granted first. M1→S2 (1010) granted in the IDLE cycle after M0's RLAST.
- M1 ARADDR = 0x2000_0040, ARREADY_S[4] held low 3 cycles → state 01 for 3 cycles with ARID_control = 1100, then 10.
- M0 ARADDR = 0x3000_0000 → ARID_control = 0101. The default slave's ARREADY and RLAST complete the transaction.
- Burst of 4 beats on S2 with RREADY_M1 deasserted for 2 cycles → stays in 10 until the 4th beat with RLAST. ARREADY_S toggling during this time is ignored.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, RVALID never asserted in DATA → timeout_err pulses on the 8th DATA cycle; state 00 on the next cycle. Separately, ARESET mid-DATA → outputs return to reset values immediately.
